peg_pkt_sf_fifo: RTL and testbench

- Store-and-forward packet buffer on the packet bus (valid/sop/eop/data/ready/error).
- Sits directly downstream of the RMII RX packet producer and ahead of the packet consumer.
- Accepts a whole packet and forwards it only after its eop has been accepted error-free. Errored, overflowing or malformed packets are discarded, so downstream sees only complete packets.

---
 rtl/peg_pkt_sf_fifo.sv | 283 ++++++++++++++++++++++++++++
 tb/tb_peg_pkt_sf_fifo.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/peg_pkt_sf_fifo.sv
// peg_pkt_sf_fifo: store-and-forward packet buffer on the valid/sop/eop packet bus.
// A packet is written into the data buffer and only becomes visible to the read
// side once its eop has been accepted cleanly; errored, overflowing, malformed or
// descriptor-full packets are rewound and counted in drop_cnt.
// Optional feature macro: PEG_PKT_SF_FIFO_ERR_FWD_EN (errored packets are committed
// and flagged on out_error at their eop beat instead of being dropped).
module peg_pkt_sf_fifo #(
  parameter int WIDTH     = 8,
  parameter int DEPTH     = 2048,
  parameter int PKT_DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  input  logic                       in_sop,
  input  logic                       in_eop,
  input  logic [WIDTH-1:0]           in_data,
  input  logic                       in_error,
  output logic                       in_ready,
  output logic                       out_valid,
  output logic                       out_sop,
  output logic                       out_eop,
  output logic [WIDTH-1:0]           out_data,
  output logic                       out_error,
  input  logic                       out_ready,
  output logic [$clog2(PKT_DEPTH):0] pkt_cnt,
  output logic [15:0]                drop_cnt
);
  localparam int AW = $clog2(DEPTH);
  localparam int PW = $clog2(PKT_DEPTH);
  localparam logic [AW:0] DEPTH_V     = (AW+1)'(DEPTH);
  localparam logic [AW:0] ONE_L       = (AW+1)'(1);
  localparam logic [PW:0] PKT_DEPTH_V = (PW+1)'(PKT_DEPTH);
`ifdef PEG_PKT_SF_FIFO_ERR_FWD_EN
  localparam bit ERR_FWD = 1'b1;
`else
  localparam bit ERR_FWD = 1'b0;
`endif

  typedef enum logic [1:0] {W_IDLE, W_WR, W_DROP} wr_state_t;
  typedef enum logic {R_IDLE, R_RD} rd_state_t;

  function automatic logic [15:0] sat_add(input logic [15:0] a, input logic [1:0] inc);
    logic [16:0] s;
    s = {1'b0, a} + {15'd0, inc};
    return s[16] ? 16'hFFFF : s[15:0];
  endfunction

  logic [WIDTH-1:0] mem        [DEPTH];
  logic [AW-1:0]    desc_start [PKT_DEPTH];
  logic [AW:0]      desc_len   [PKT_DEPTH];
  logic             desc_err   [PKT_DEPTH];

  wr_state_t  wr_state, wr_next;
  logic [AW:0] wr_ptr, wr_ptr_n, start_ptr, start_n, wr_len, len_n, base, push_len;
  logic [AW:0] rd_ptr, out_beats;
  logic        err_seen, err_n, we, push, push_err;
  logic [1:0]  drop_inc;
  logic [PW:0] desc_wp, desc_rp;

  rd_state_t  rd_state, rd_next;
  logic [AW-1:0] rd_addr;
  logic [AW:0]   rd_left;
  logic          rd_first, rd_err, desc_avail, desc_pop, issue, last_issue, pop_out;
  logic [1:0]    held;
  logic             vld_p1, sop_p1, eop_p1, err_p1;
  logic [WIDTH-1:0] data_p1;
  logic             skid_vld, skid_sop, skid_eop, skid_err, out_err_q;
  logic [WIDTH-1:0] skid_data;

  // Write FSM next state: commit, rewind or discard the beat being accepted
  always_comb begin
    wr_next  = wr_state;
    wr_ptr_n = wr_ptr;
    start_n  = start_ptr;
    len_n    = wr_len;
    err_n    = err_seen;
    we       = 1'b0;
    push     = 1'b0;
    push_len = wr_len;
    push_err = err_seen;
    drop_inc = 2'd0;
    base     = wr_ptr;
    if (in_valid && in_ready) begin
      if (in_sop) begin
        // a sop inside a packet abandons the partial packet and restarts at its start
        if (wr_state == W_WR) begin
          base     = start_ptr;
          drop_inc = 2'd1;
        end
        wr_ptr_n = base;
        if (pkt_cnt == PKT_DEPTH_V || (in_error && !ERR_FWD) || (base - rd_ptr) == DEPTH_V) begin
          drop_inc = drop_inc + 2'd1;
          wr_next  = in_eop ? W_IDLE : W_DROP;
        end else begin
          we       = 1'b1;
          wr_ptr_n = base + 1'b1;
          start_n  = base;
          len_n    = ONE_L;
          err_n    = in_error;
          if (in_eop) begin
            push     = 1'b1;
            push_len = ONE_L;
            push_err = in_error;
            wr_next  = W_IDLE;
          end else begin
            wr_next  = W_WR;
          end
        end
      end else if (wr_state == W_WR) begin
        if ((in_error && !ERR_FWD) || (wr_ptr - rd_ptr) == DEPTH_V) begin
          drop_inc = 2'd1;
          wr_ptr_n = start_ptr;
          wr_next  = in_eop ? W_IDLE : W_DROP;
        end else begin
          we       = 1'b1;
          wr_ptr_n = wr_ptr + 1'b1;
          len_n    = wr_len + 1'b1;
          err_n    = err_seen | in_error;
          if (in_eop) begin
            push     = 1'b1;
            push_len = wr_len + 1'b1;
            push_err = err_seen | in_error;
            wr_next  = W_IDLE;
          end
        end
      end else if (wr_state == W_DROP && in_eop) begin
        wr_next = W_IDLE;
      end
    end
  end

  // Write-side control registers and saturating drop counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_state  <= W_IDLE;
      wr_ptr    <= '0;
      start_ptr <= '0;
      wr_len    <= '0;
      err_seen  <= 1'b0;
      desc_wp   <= '0;
      drop_cnt  <= '0;
      in_ready  <= 1'b0;
    end else begin
      in_ready  <= 1'b1;
      wr_state  <= wr_next;
      wr_ptr    <= wr_ptr_n;
      start_ptr <= start_n;
      wr_len    <= len_n;
      err_seen  <= err_n;
      if (push) desc_wp <= desc_wp + 1'b1;
      drop_cnt  <= sat_add(drop_cnt, drop_inc);
    end
  end

  // Data buffer and descriptor storage writes
  always_ff @(posedge clk) begin
    if (we) mem[base[AW-1:0]] <= in_data;
    if (push) begin
      desc_start[desc_wp[PW-1:0]] <= start_n[AW-1:0];
      desc_len[desc_wp[PW-1:0]]   <= push_len;
      desc_err[desc_wp[PW-1:0]]   <= push_err;
    end
  end

  assign desc_avail = (desc_wp != desc_rp);
  assign pop_out    = out_valid && out_ready;
  assign held       = 2'(out_valid) + 2'(skid_vld) + 2'(vld_p1);
  assign issue      = (rd_state == R_RD) && (held < 2'd2 || pop_out);
  assign last_issue = issue && (rd_left == ONE_L);

  // Read FSM next state: chain descriptors without a bubble
  always_comb begin
    rd_next  = rd_state;
    desc_pop = 1'b0;
    case (rd_state)
      R_IDLE: if (desc_avail) begin
        desc_pop = 1'b1;
        rd_next  = R_RD;
      end
      R_RD: if (last_issue) begin
        if (desc_avail) desc_pop = 1'b1;
        else            rd_next  = R_IDLE;
      end
      default: rd_next = R_IDLE;
    endcase
  end

  // Read-side control: descriptor pop, read address, buffer free and packet count
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_state  <= R_IDLE;
      desc_rp   <= '0;
      rd_addr   <= '0;
      rd_left   <= '0;
      rd_first  <= 1'b0;
      rd_err    <= 1'b0;
      vld_p1    <= 1'b0;
      rd_ptr    <= '0;
      out_beats <= '0;
      pkt_cnt   <= '0;
    end else begin
      rd_state <= rd_next;
      vld_p1   <= issue;
      if (desc_pop) begin
        desc_rp  <= desc_rp + 1'b1;
        rd_addr  <= desc_start[desc_rp[PW-1:0]];
        rd_left  <= desc_len[desc_rp[PW-1:0]];
        rd_err   <= desc_err[desc_rp[PW-1:0]];
        rd_first <= 1'b1;
      end else if (issue) begin
        rd_addr  <= rd_addr + 1'b1;
        rd_left  <= rd_left - 1'b1;
        rd_first <= 1'b0;
      end
      if (pop_out) begin
        if (out_eop) begin
          rd_ptr    <= rd_ptr + out_beats + 1'b1;
          out_beats <= '0;
        end else begin
          out_beats <= out_beats + 1'b1;
        end
      end
      if (push && !(pop_out && out_eop))      pkt_cnt <= pkt_cnt + 1'b1;
      else if (!push && pop_out && out_eop)   pkt_cnt <= pkt_cnt - 1'b1;
    end
  end

  // ---- stage p1: buffer read data (1-cycle read latency) ----
  always_ff @(posedge clk) begin
    if (issue) begin
      data_p1 <= mem[rd_addr];
      sop_p1  <= rd_first;
      eop_p1  <= (rd_left == ONE_L);
      err_p1  <= rd_err && (rd_left == ONE_L);
    end
  end

  // ---- stage p2: registered output plus one-entry skid, held while stalled ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_sop   <= 1'b0;
      out_eop   <= 1'b0;
      out_data  <= '0;
      out_err_q <= 1'b0;
      skid_vld  <= 1'b0;
      skid_sop  <= 1'b0;
      skid_eop  <= 1'b0;
      skid_err  <= 1'b0;
      skid_data <= '0;
    end else if (pop_out && skid_vld) begin
      out_sop   <= skid_sop;
      out_eop   <= skid_eop;
      out_data  <= skid_data;
      out_err_q <= skid_err;
      skid_vld  <= vld_p1;
      if (vld_p1) begin
        skid_sop  <= sop_p1;
        skid_eop  <= eop_p1;
        skid_data <= data_p1;
        skid_err  <= err_p1;
      end
    end else if (pop_out || !out_valid) begin
      out_valid <= vld_p1;
      if (vld_p1) begin
        out_sop   <= sop_p1;
        out_eop   <= eop_p1;
        out_data  <= data_p1;
        out_err_q <= err_p1;
      end
    end else if (vld_p1) begin
      skid_vld  <= 1'b1;
      skid_sop  <= sop_p1;
      skid_eop  <= eop_p1;
      skid_data <= data_p1;
      skid_err  <= err_p1;
    end
  end

  assign out_error = ERR_FWD ? out_err_q : 1'b0;

endmodule

// File: tb/tb_peg_pkt_sf_fifo.sv
// Testbench for peg_pkt_sf_fifo: directed and random packets against a
// packet-level reference model (expected beat queue, packet/beat occupancy).
module tb_peg_pkt_sf_fifo;
  localparam int WIDTH     = 8;
  localparam int DEPTH     = 2048;
  localparam int PKT_DEPTH = 16;
`ifdef PEG_PKT_SF_FIFO_ERR_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic in_valid = 1'b0, in_sop = 1'b0, in_eop = 1'b0, in_error = 1'b0;
  logic [WIDTH-1:0] in_data = '0;
  logic in_ready, out_valid, out_sop, out_eop, out_error;
  logic [WIDTH-1:0] out_data;
  logic out_ready = 1'b0;
  logic [$clog2(PKT_DEPTH):0] pkt_cnt;
  logic [15:0] drop_cnt;

  peg_pkt_sf_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH), .PKT_DEPTH(PKT_DEPTH)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_sop(in_sop), .in_eop(in_eop), .in_data(in_data),
    .in_error(in_error), .in_ready(in_ready),
    .out_valid(out_valid), .out_sop(out_sop), .out_eop(out_eop), .out_data(out_data),
    .out_error(out_error), .out_ready(out_ready),
    .pkt_cnt(pkt_cnt), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  // reference model state
  logic [10:0] exp_q[$];
  int len_q[$];
  int model_pkts = 0, model_buf = 0, model_drops = 0;
  int eop_cyc = 0, sop_cyc = -1;
  int beats_seen = 0, sops_seen = 0, eops_seen = 0;

  // egress ready pattern: 0 fixed, 1 toggle, 2 random
  int rdy_mode = 0;
  logic rdy_fixed = 1'b0;
  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0:       out_ready = rdy_fixed;
      1:       out_ready = ~out_ready;
      default: out_ready = 1'($urandom_range(0, 1));
    endcase
  end

  // egress monitor: beat order/content and hold-while-stalled
  logic [10:0] cur_beat, prev_beat, exp_beat;
  bit stalled = 1'b0;
  always @(negedge clk) begin
    cur_beat = {out_data, out_sop, out_eop, out_error};
    if (rst) begin
      stalled = 1'b0;
    end else begin
      if (stalled) begin
        checks++;
        assert (out_valid === 1'b1 && cur_beat === prev_beat)
        else begin errors++; $error("FAIL hold got %h/%b exp %h/1", cur_beat, out_valid, prev_beat); end
      end
      if (out_valid && out_ready) begin
        beats_seen++;
        if (out_sop) begin sops_seen++; if (sop_cyc < 0) sop_cyc = cyc; end
        if (out_eop) eops_seen++;
        checks++;
        assert (exp_q.size() != 0)
        else begin errors++; $error("FAIL unexpected_beat got %h exp none", cur_beat); end
        if (exp_q.size() != 0) begin
          exp_beat = exp_q.pop_front();
          checks++;
          assert (cur_beat === exp_beat)
          else begin errors++; $error("FAIL beat got %h exp %h", cur_beat, exp_beat); end
          if (exp_beat[1] && len_q.size() != 0) begin
            model_pkts--;
            model_buf -= len_q.pop_front();
          end
        end
      end
      stalled = out_valid && !out_ready;
      prev_beat = cur_beat;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp)
    else begin errors++; $error("FAIL %s got %0d exp %0d", tag, got, exp); end
  endtask

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // drives one packet; base<0 gives random data; err_idx<0 means no error
  task automatic send_pkt(input int len, input int base, input int err_idx);
    bit drop, has_err;
    logic [7:0] d;
    has_err = (err_idx >= 0 && err_idx < len);
    drop = (model_pkts >= PKT_DEPTH) || (has_err && !FWD) || (len > DEPTH - model_buf);
    if (drop) model_drops++;
    else begin model_pkts++; model_buf += len; len_q.push_back(len); end
    for (int i = 0; i < len; i++) begin
      d = (base < 0) ? 8'($urandom) : 8'(base + i);
      in_valid = 1'b1; in_sop = (i == 0); in_eop = (i == len - 1);
      in_data = d; in_error = (i == err_idx);
      if (!drop) exp_q.push_back({d, i == 0, i == len - 1, FWD && has_err && i == len - 1});
      @(posedge clk); #1;
    end
    in_valid = 1'b0; in_sop = 1'b0; in_eop = 1'b0; in_error = 1'b0;
    eop_cyc = cyc;
  endtask

  task automatic wait_drain(input string tag);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || out_valid) && n < 5000) begin tick(1); n++; end
    tick(6);
    checks++;
    assert (exp_q.size() == 0 && !out_valid)
    else begin errors++; $error("FAIL %s drain left %0d exp 0", tag, exp_q.size()); end
  endtask

  initial begin
    int b0, s0, e0, n, len, err;
    // reset state
    tick(3);
    check("reset_outs", {in_ready, out_valid, out_sop, out_eop, out_data, out_error}, 0);
    check("reset_pkt_cnt", pkt_cnt, 0);
    check("reset_drop_cnt", drop_cnt, 0);
    @(posedge clk); #1; rst = 1'b0;
    tick(1);
    check("in_ready_after_reset", in_ready, 1);

    // single 64-beat packet, latency and pkt_cnt
    rdy_fixed = 1'b1; tick(3);
    sop_cyc = -1; b0 = beats_seen;
    send_pkt(64, 0, -1);
    check("pkt_cnt_after_eop", pkt_cnt, 1);
    wait_drain("pkt64");
    check("latency", sop_cyc - eop_cyc, 3);
    check("pkt64_beats", beats_seen - b0, 64);
    check("pkt64_pkt_cnt", pkt_cnt, 0);

    // back-to-back 1/5/60 with toggling out_ready
    rdy_mode = 1;
    b0 = beats_seen; s0 = sops_seen; e0 = eops_seen;
    send_pkt(1, 8'h10, -1);
    send_pkt(5, 8'h20, -1);
    send_pkt(60, 8'h40, -1);
    wait_drain("b2b");
    check("b2b_beats", beats_seen - b0, 66);
    check("b2b_sops", sops_seen - s0, 3);
    check("b2b_eops", eops_seen - e0, 3);
    rdy_mode = 0; rdy_fixed = 1'b1; tick(2);

    // errored packet then clean packet
    b0 = beats_seen;
    send_pkt(10, 8'h80, 3);
    send_pkt(8, 8'hA0, -1);
    wait_drain("err");
    check("err_beats", beats_seen - b0, FWD ? 18 : 8);
    check("err_drop_cnt", drop_cnt, model_drops);

    // oversize packet with egress stalled, then a normal one
    rdy_fixed = 1'b0; tick(2);
    send_pkt(DEPTH + 1, -1, -1);
    tick(2);
    check("oversize_drop_cnt", drop_cnt, model_drops);
    check("oversize_pkt_cnt", pkt_cnt, 0);
    send_pkt(16, 8'h30, -1);
    tick(2);
    check("after_oversize_pkt_cnt", pkt_cnt, 1);
    rdy_fixed = 1'b1;
    wait_drain("oversize");
    check("oversize_drained", pkt_cnt, 0);

    // descriptor FIFO full
    rdy_fixed = 1'b0; tick(2);
    for (int i = 0; i < PKT_DEPTH + 1; i++) send_pkt(1, 8'h50 + i, -1);
    tick(2);
    check("desc_full_pkt_cnt", pkt_cnt, PKT_DEPTH);
    check("desc_full_drop_cnt", drop_cnt, model_drops);
    rdy_fixed = 1'b1;
    wait_drain("desc_full");
    check("desc_full_drained", pkt_cnt, 0);

    // random packets, random errors, random egress stalls and gaps
    rdy_mode = 2;
    for (int p = 0; p < 40; p++) begin
      n = 0;
      while (model_pkts >= 8 && n < 2000) begin tick(1); n++; end
      tick($urandom_range(0, 3));
      len = $urandom_range(1, 20);
      err = ($urandom_range(0, 4) == 0) ? $urandom_range(0, len - 1) : -1;
      send_pkt(len, -1, err);
    end
    rdy_mode = 0; rdy_fixed = 1'b1;
    wait_drain("random");
    check("random_drop_cnt", drop_cnt, model_drops);
    check("random_pkt_cnt", pkt_cnt, 0);

    // reset with two packets buffered and one partial
    rdy_fixed = 1'b0; tick(2);
    send_pkt(3, 8'h60, -1);
    send_pkt(4, 8'h70, -1);
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; in_sop = (i == 0); in_eop = 1'b0; in_data = 8'($urandom);
      tick(1);
    end
    in_valid = 1'b0; in_sop = 1'b0;
    rst = 1'b1;
    #1;
    check("midrst_outs", {in_ready, out_valid, out_sop, out_eop, out_data, out_error}, 0);
    check("midrst_pkt_cnt", pkt_cnt, 0);
    check("midrst_drop_cnt", drop_cnt, 0);
    exp_q.delete(); len_q.delete();
    model_pkts = 0; model_buf = 0; model_drops = 0;
    tick(2);
    rst = 1'b0;
    tick(1);
    check("midrst_in_ready", in_ready, 1);
    rdy_fixed = 1'b1; tick(2);
    b0 = beats_seen;
    send_pkt(12, 8'h90, -1);
    wait_drain("post_reset");
    check("post_reset_beats", beats_seen - b0, 12);
    check("post_reset_pkt_cnt", pkt_cnt, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // global watchdog
  initial begin
    #2000000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1, "timeout");
  end

endmodule
